booth_r8_operand_stage: RTL and testbench

//   Registered radix-8 Booth operand stage, directly upstream of mb16_top.
//   Per cycle it accepts one unsigned pair (mx, my) and produces:
//   - one-hot digit selects s/d/t/q/n for each 3-bit group of mx;
//   - my, passed through unchanged;
//   - tmy = 3*my, the hard multiple.

---
 rtl/booth_r8_pkg.sv | 57 +++++
 rtl/booth_r8_digit_enc.sv | 30 +++
 rtl/booth_r8_operand_stage.sv | 145 ++++++++++++++
 tb/tb_booth_r8_operand_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_r8_pkg.sv
// ---------------------------------------------------------------------------
// booth_r8_pkg
//   Shared definitions for the radix-8 Booth operand stage:
//   - group_cnt()    : number of 3-bit Booth groups for a given operand width
//   - digit_sel_t    : one-hot digit select, field order {s,d,t,q,n}
//   - booth_encode() : 4-bit window {x[3i+2],x[3i+1],x[3i],x[3i-1]} -> select
//   - state encodings for the operand-stage handshake FSM
// ---------------------------------------------------------------------------
package booth_r8_pkg;

  // Two extra groups cover the zero-extension that keeps the most
  // significant digit non-negative for an unsigned operand.
  function automatic int group_cnt(input int width);
    return (width >> 2) + 2;
  endfunction

  // s,d,t,q : |digit| = 1,2,3,4 (one-hot, all zero for a zero digit)
  // n       : digit is negative (never set for a zero digit)
  typedef struct packed {
    logic s;
    logic d;
    logic t;
    logic q;
    logic n;
  } digit_sel_t;

  localparam int SEL_W = $bits(digit_sel_t);

  localparam logic [1:0] ST_EMPTY_ENC = 2'd0;
  localparam logic [1:0] ST_ONE_ENC   = 2'd1;
  localparam logic [1:0] ST_FULL_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = ST_EMPTY_ENC,
    ST_ONE   = ST_ONE_ENC,
    ST_FULL  = ST_FULL_ENC
  } stage_state_t;

  // Digit = -4*w[3] + 2*w[2] + w[1] + w[0]
  function automatic digit_sel_t booth_encode(input logic [3:0] win);
    digit_sel_t sel;
    sel = '0;
    case (win)
      4'b0001, 4'b0010: sel.s = 1'b1;                    // +1
      4'b0011, 4'b0100: sel.d = 1'b1;                    // +2
      4'b0101, 4'b0110: sel.t = 1'b1;                    // +3
      4'b0111:          sel.q = 1'b1;                    // +4
      4'b1000:          begin sel.q = 1'b1; sel.n = 1'b1; end  // -4
      4'b1001, 4'b1010: begin sel.t = 1'b1; sel.n = 1'b1; end  // -3
      4'b1011, 4'b1100: begin sel.d = 1'b1; sel.n = 1'b1; end  // -2
      4'b1101, 4'b1110: begin sel.s = 1'b1; sel.n = 1'b1; end  // -1
      default:          sel = '0;                        // 0000 / 1111 -> 0
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_r8_digit_enc.sv
// ---------------------------------------------------------------------------
// booth_r8_digit_enc
//   Combinational radix-8 Booth digit encoder for one 4-bit window.
// Ports
//   win        in   4   {x[3i+2], x[3i+1], x[3i], x[3i-1]}
//   s,d,t,q    out  1   |digit| = 1,2,3,4 one-hot (all 0 for digit 0)
//   n          out  1   digit negative
// ---------------------------------------------------------------------------
module booth_r8_digit_enc
  import booth_r8_pkg::*;
(
  input  logic [3:0] win,
  output logic       s,
  output logic       d,
  output logic       t,
  output logic       q,
  output logic       n
);

  digit_sel_t sel;

  assign sel = booth_encode(win);

  assign s = sel.s;
  assign d = sel.d;
  assign t = sel.t;
  assign q = sel.q;
  assign n = sel.n;

endmodule

// File: rtl/booth_r8_operand_stage.sv
// ---------------------------------------------------------------------------
// booth_r8_operand_stage
//   Registered radix-8 Booth operand stage feeding mb16_top. Each accepted
//   unsigned pair (mx, my) yields per-group one-hot digit selects for mx,
//   my passed through, and the hard multiple tmy = 3*my. Encoding and tmy
//   are computed ahead of the registers so the consumer sees flop outputs
//   only. A one-entry skid buffer behind the output register keeps in_ready
//   a pure flop output (no out_ready -> in_ready combinational path).
//
//   The group count covers the zero-extended operand exactly while
//   3*GROUP_CNT >= WIDTH+1, i.e. for WIDTH of 8, 12, 16 or 20.
//
// Ports
//   CLK        in   1            clock, rising edge
//   RST        in   1            asynchronous reset, active low
//   in_valid   in   1            mx/my valid
//   in_ready   out  1            stage can accept (registered, = !skid_full)
//   mx         in   WIDTH        multiplier operand (Booth-encoded)
//   my         in   WIDTH        multiplicand operand
//   out_valid  out  1            outputs valid
//   out_ready  in   1            consumer takes the current output
//   s,d,t,q,n  out  GROUP_CNT    per-group digit select / sign
//   my_o       out  WIDTH        registered my
//   tmy        out  WIDTH+2      3*my, exact
// ---------------------------------------------------------------------------
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_EMPTY | nothing held; out_valid=0, in_ready=1
//   ST_ONE   | output register valid, skid empty; in_ready=1
//   ST_FULL  | output register and skid both valid; in_ready=0
// ---------------------------------------------------------------------------
module booth_r8_operand_stage
  import booth_r8_pkg::*;
#(
  parameter  int WIDTH     = 16,
  localparam int GROUP_CNT = group_cnt(WIDTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     mx,
  input  logic [WIDTH-1:0]     my,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [GROUP_CNT-1:0] s,
  output logic [GROUP_CNT-1:0] d,
  output logic [GROUP_CNT-1:0] t,
  output logic [GROUP_CNT-1:0] q,
  output logic [GROUP_CNT-1:0] n,
  output logic [WIDTH-1:0]     my_o,
  output logic [WIDTH+1:0]     tmy
);

  // Extended multiplier: bit 0 is x[-1] = 0, then mx, then zero padding.
  localparam int EXT_W = 3 * GROUP_CNT + 1;
  localparam int PAD_W = EXT_W - WIDTH - 1;
  localparam int PAY_W = SEL_W * GROUP_CNT + WIDTH + WIDTH + 2;

  logic [EXT_W-1:0]     mx_ext;
  logic [GROUP_CNT-1:0] s_c;
  logic [GROUP_CNT-1:0] d_c;
  logic [GROUP_CNT-1:0] t_c;
  logic [GROUP_CNT-1:0] q_c;
  logic [GROUP_CNT-1:0] n_c;
  logic [WIDTH+1:0]     tmy_c;
  logic [PAY_W-1:0]     pay_c;
  logic [PAY_W-1:0]     out_q;
  logic [PAY_W-1:0]     skid_q;
  logic                 in_xfer;
  stage_state_t         state;

  assign mx_ext = {{PAD_W{1'b0}}, mx, 1'b0};

  // Window for group g is mx_ext[3g+3:3g] = {x[3g+2], x[3g+1], x[3g], x[3g-1]}.
  generate
    for (genvar g = 0; g < GROUP_CNT; g++) begin : g_enc
      booth_r8_digit_enc u_enc (
        .win (mx_ext[3*g+3 -: 4]),
        .s   (s_c[g]),
        .d   (d_c[g]),
        .t   (t_c[g]),
        .q   (q_c[g]),
        .n   (n_c[g])
      );
    end
  endgenerate

  // Two guard bits make my + 2*my exact for any unsigned my.
  assign tmy_c = {2'b00, my} + {1'b0, my, 1'b0};

  assign pay_c = {s_c, d_c, t_c, q_c, n_c, my, tmy_c};

  assign {s, d, t, q, n, my_o, tmy} = out_q;

  // in_ready is low only in ST_FULL, so no input is taken while full.
  assign in_xfer = in_valid & in_ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_q     <= '0;
      skid_q    <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            out_q     <= pay_c;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && !out_ready) begin
            // Output is stalled: park the new pair and stop accepting.
            skid_q   <= pay_c;
            in_ready <= 1'b0;
            state    <= ST_FULL;
          end else if (in_xfer) begin
            // Output consumed this edge; replace it with the new pair.
            out_q <= pay_c;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            out_q    <= skid_q;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r8_operand_stage.sv
module tb_booth_r8_operand_stage;

  localparam int W  = 16;
  localparam int GC = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  mx = '0;
  logic [W-1:0]  my = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [GC-1:0] s, d, t, q, n;
  logic [W-1:0]  my_o;
  logic [W+1:0]  tmy;

  int checks   = 0;
  int failures = 0;

  // Reference model: a FIFO of accepted pairs, capacity 2.
  logic [W-1:0] mq_mx[$];
  logic [W-1:0] mq_my[$];
  int           model_in_cnt = 0;
  int           dut_out_cnt  = 0;
  bit           m_ix, m_ox;

  booth_r8_operand_stage #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mx        (mx),
    .my        (my),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .d         (d),
    .t         (t),
    .q         (q),
    .n         (n),
    .my_o      (my_o),
    .tmy       (tmy)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected selects straight from the digit formula.
  task automatic exp_sel(input logic [W-1:0] x,
                         output logic [GC-1:0] es, ed, et, eq, en);
    int e, w, dg, m;
    es = '0; ed = '0; et = '0; eq = '0; en = '0;
    e = int'(x) << 1;
    for (int i = 0; i < GC; i++) begin
      w  = (e >> (3 * i)) & 15;
      dg = -4 * ((w >> 3) & 1) + 2 * ((w >> 2) & 1) + ((w >> 1) & 1) + (w & 1);
      m  = (dg < 0) ? -dg : dg;
      es[i] = (m == 1);
      ed[i] = (m == 2);
      et[i] = (m == 3);
      eq[i] = (m == 4);
      en[i] = (dg < 0);
    end
  endtask

  function automatic longint digit_sum(input logic [GC-1:0] fs, fd, ft, fq, fn);
    longint acc, m;
    acc = 0;
    for (int i = 0; i < GC; i++) begin
      m = fs[i] ? 1 : fd[i] ? 2 : ft[i] ? 3 : fq[i] ? 4 : 0;
      if (fn[i]) m = -m;
      acc += m * (longint'(1) << (3 * i));
    end
    return acc;
  endfunction

  // Model update on every edge (and immediately on async reset).
  initial begin
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) begin
        mq_mx.delete();
        mq_my.delete();
      end else begin
        m_ix = in_valid && (mq_mx.size() < 2);
        m_ox = out_ready && (mq_mx.size() > 0);
        if (m_ox) begin
          void'(mq_mx.pop_front());
          void'(mq_my.pop_front());
        end
        if (m_ix) begin
          mq_mx.push_back(mx);
          mq_my.push_back(my);
          model_in_cnt++;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  initial begin
    logic [GC-1:0] es, ed, et, eq, en;
    longint dsum;
    forever begin
      @(negedge CLK);
      if (RST) begin
        chk("out_valid", 64'(out_valid), 64'(mq_mx.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(mq_mx.size() < 2));
        if (out_valid && mq_mx.size() > 0) begin
          exp_sel(mq_mx[0], es, ed, et, eq, en);
          chk("sel_s", 64'(s), 64'(es));
          chk("sel_d", 64'(d), 64'(ed));
          chk("sel_t", 64'(t), 64'(et));
          chk("sel_q", 64'(q), 64'(eq));
          chk("sel_n", 64'(n), 64'(en));
          chk("my_o", 64'(my_o), 64'(mq_my[0]));
          chk("tmy", 64'(tmy), 64'(mq_my[0]) * 64'd3);
          dsum = digit_sum(s, d, t, q, n);
          chk("digit_sum", 64'(dsum), 64'(mq_mx[0]));
          chk("booth_prod", 64'(dsum * longint'(my_o)), 64'(mq_mx[0]) * 64'(mq_my[0]));
        end
        if (out_valid && out_ready) dut_out_cnt++;
      end
    end
  end

  task automatic drain(input string nm);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8 && out_valid; k++) tick();
    chk(nm, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [W-1:0] vec_tab [6];
    int ir_drop;
    int in_base, out_base;

    vec_tab = '{16'h0000, 16'hFFFF, 16'h8000, 16'hAAAA, 16'h5555, 16'h7FFF};

    repeat (3) tick();
    RST = 1'b1;
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_data", 64'({s, d, t, q, n}), 64'd0);
    chk("rst_tmy", 64'(tmy), 64'd0);

    // 1: single pair, 1-cycle latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    mx = 16'h0007;
    my = 16'h0001;
    chk("t1_pre_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_s", 64'(s), 64'b000011);
    chk("t1_n", 64'(n), 64'b000001);
    chk("t1_dtq", 64'({d, t, q}), 64'd0);
    chk("t1_tmy", 64'(tmy), 64'h3);
    tick();
    chk("t1_done", 64'(out_valid), 64'd0);

    // 2: boundary encodings, back to back
    in_valid = 1'b1;
    mx = 16'h0004;
    my = 16'h0005;
    tick();
    chk("t2a_q", 64'(q), 64'b000001);
    chk("t2a_n", 64'(n), 64'b000001);
    chk("t2a_s", 64'(s), 64'b000010);
    chk("t2a_tmy", 64'(tmy), 64'd15);
    mx = 16'hFFFF;
    my = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    chk("t2b_s", 64'(s), 64'b000001);
    chk("t2b_n", 64'(n), 64'b000001);
    chk("t2b_d", 64'(d), 64'b100000);
    chk("t2b_tq", 64'({t, q}), 64'd0);
    chk("t2b_tmy", 64'(tmy), 64'h2FFFD);
    drain("t2_drain");

    // 3: 100 back-to-back pairs with out_ready held high
    ir_drop  = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      mx = (i < 6) ? vec_tab[i] : 16'($urandom);
      my = 16'($urandom);
      tick();
      if (!in_ready) ir_drop++;
    end
    chk("t3_in_ready_drops", 64'(ir_drop), 64'd0);
    drain("t3_drain");

    // 4: stall with A in output, B in skid, C refused
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mx = 16'h0007; my = 16'h1111;
    tick();
    mx = 16'h0004; my = 16'h2222;
    tick();
    chk("t4_ir_low", 64'(in_ready), 64'd0);
    chk("t4_hold_a1", 64'(my_o), 64'h1111);
    mx = 16'h0009; my = 16'h3333;
    tick();
    chk("t4_hold_a2", 64'(my_o), 64'h1111);
    chk("t4_hold_s", 64'(s), 64'b000011);
    chk("t4_ir_still_low", 64'(in_ready), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t4_b_out", 64'(my_o), 64'h2222);
    chk("t4_ir_back", 64'(in_ready), 64'd1);
    tick();
    chk("t4_empty", 64'(out_valid), 64'd0);

    // 5: async reset with skid full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mx = 16'h0123; my = 16'h0456;
    tick();
    mx = 16'h0789; my = 16'h0ABC;
    tick();
    in_valid = 1'b0;
    chk("t5_full", 64'(in_ready), 64'd0);
    #2;
    RST = 1'b0;
    #1;
    chk("t5_async_ov", 64'(out_valid), 64'd0);
    chk("t5_async_ir", 64'(in_ready), 64'd1);
    chk("t5_async_data", 64'({s, d, t, q, n, my_o}), 64'd0);
    tick();
    tick();
    RST = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    mx = 16'h0055; my = 16'h0011;
    tick();
    in_valid = 1'b0;
    chk("t5_first_valid", 64'(out_valid), 64'd1);
    chk("t5_first_my", 64'(my_o), 64'h0011);
    chk("t5_first_t", 64'(t), 64'b000011);
    chk("t5_first_s", 64'(s), 64'b000100);
    chk("t5_first_n", 64'(n), 64'b000001);
    drain("t5_drain");

    // 6: random handshake traffic
    in_base  = model_in_cnt;
    out_base = dut_out_cnt;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      mx = 16'($urandom);
      my = 16'($urandom);
      tick();
    end
    drain("t6_drain");
    chk("t6_no_drop_dup", 64'(dut_out_cnt - out_base), 64'(model_in_cnt - in_base));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
